qtree_ram_stage: RTL and testbench
==================================

Name: qtree_ram_stage

Overview:
Lookup-level memory stage for the quadtree search pipeline. A simple dual-port RAM has one write port driven by the memory-mapped config path and one synchronous read port driven by the lookup pipeline. A sideband bypass word and a valid bit are carried alongside each read so they leave the block aligned with the read data. An optional extra output register stage exists for timing closure.

Parameters:
DATA_WIDTH, 16, RAM word width in bits.
ADDR_WIDTH, 4, RAM address width; depth = 2**ADDR_WIDTH words.
BYPASS_WIDTH, 1, width of the sideband word delayed alongside the read.
OUT_REG_ENABLE, 0, 1 adds one register stage after the RAM read (data, bypass and valid); 0 means no extra stage.

Ports:
clk_i  input  1  single clock; all logic is rising-edge.
rst_i  input  1  reset, synchronous, active-high.
wr_addr_i  input  ADDR_WIDTH  write address.
wr_data_i  input  DATA_WIDTH  write data.
wr_enable_i  input  1  write strobe; one word is written per cycle while high.
in_read_addr_i  input  ADDR_WIDTH  read address; sampled every cycle.
in_bypass_i  input  BYPASS_WIDTH  sideband word accompanying the read.
in_valid_i  input  1  qualifies the read and bypass inputs.
out_read_data_o  output  DATA_WIDTH  RAM word read at in_read_addr_i.
out_bypass_o  output  BYPASS_WIDTH  in_bypass_i, delayed to match the read data.
out_valid_o  output  1  in_valid_i, delayed to match the read data.

Behaviour:
- Latency: L = 1 + OUT_REG_ENABLE cycles from an input sample to the matching output, for data, bypass and valid alike.
- Throughput is one read per cycle. There is no backpressure and no stall.
- Read port:
  - Registered synchronous read every cycle, regardless of in_valid_i.
  - Outputs are meaningful only while out_valid_o = 1.
- Write port: on a rising edge with wr_enable_i = 1, mem[wr_addr_i] <= wr_data_i.
- Read and write may target any addresses in the same cycle.
- Read-during-write to the same address returns the OLD word (read-first), unless QTREE_RAM_WR_FWD_EN is defined.
- Reset behaviour:
  - The valid pipeline and all data/bypass output registers clear to 0; after reset, out_valid_o = 0, out_read_data_o = 0, out_bypass_o = 0.
  - RAM contents are NOT cleared by reset.
  - Simulation initialises every RAM word to 0.
  - A write asserted during reset is still performed.
- Reset mid-stream: in-flight valids are dropped. The first valid after reset deasserts appears L cycles after it is sampled.
- OUT_REG_ENABLE = 0: the output register is the RAM read register itself.
- OUT_REG_ENABLE = 1: one extra register follows it; data, bypass and valid all advance together.
- Address width equals the full depth, so there is no wrap-around or out-of-range case.

Optional Feature:
Macro QTREE_RAM_WR_FWD_EN.
- Defined: when wr_enable_i = 1 and wr_addr_i == in_read_addr_i in the same cycle, the read returns wr_data_i (write-forwarding).
- Not defined: that read returns the previous contents (read-first).
- Latency is unchanged either way.

Decomposition:
- Shared package qtree_pkg holds:
  - the level RAM word typedef (three KEY_WIDTH fields l, m, r);
  - the level data typedef (lookup_value, addr);
  - the default width constants.
- The RAM array and its read register live in qtree_ram_stage.
- The extra output stage is one sub-module, pipe_delay_reg, with:
  - parameters DATA_WIDTH and ENABLE;
  - ports clk_i, rst_i, in_data_i, in_valid_i, out_data_o, out_valid_o;
  - ENABLE = 0 is a pure wire, ENABLE = 1 is one register with valid reset to 0.
- pipe_delay_reg is instantiated once with DATA_WIDTH = DATA_WIDTH + BYPASS_WIDTH.

Test Plan:
1. Reset: hold rst_i for 3 cycles with in_valid_i = 1 -> out_valid_o = 0, out_read_data_o = 0 and out_bypass_o = 0 throughout and 1 cycle after.
2. Write then read, OUT_REG_ENABLE = 0: write 0xBEEF to addr 5, then read addr 5 with bypass = 1 -> next cycle out_read_data_o = 0xBEEF, out_bypass_o = 1, out_valid_o = 1.
3. Same stimulus with OUT_REG_ENABLE = 1 -> the response appears exactly 2 cycles after the read is sampled; nothing valid at 1 cycle.
4. Read-during-write: mem[3] = 0x1111; in the same cycle write 0x2222 to addr 3 and read addr 3 -> returns 0x1111 (0x2222 if QTREE_RAM_WR_FWD_EN is defined); the next read of addr 3 returns 0x2222.
5. Back-to-back streaming: read addrs 0..15 on consecutive cycles with bypass = addr[0], mem[i] = i*3 -> outputs in order with no gaps, and each bypass is aligned with its data.
6. Valid gaps: in_valid_i pattern 1,0,1,1,0 -> out_valid_o shows the same pattern shifted by L cycles.

Source files
------------

// File: rtl/qtree_pkg.sv
// Shared types and default widths for the quadtree search pipeline.
// Level RAM word and level data typedefs are used by the stages around qtree_ram_stage.
package qtree_pkg;

  localparam int DEFAULT_DATA_WIDTH   = 16;
  localparam int DEFAULT_ADDR_WIDTH   = 4;
  localparam int DEFAULT_BYPASS_WIDTH = 1;
  localparam int KEY_WIDTH            = 16;

  // One level RAM word: left, middle and right split keys of a node.
  typedef struct packed {
    logic [KEY_WIDTH-1:0] l;
    logic [KEY_WIDTH-1:0] m;
    logic [KEY_WIDTH-1:0] r;
  } levelRamWord_t;

  typedef struct packed {
    logic [KEY_WIDTH-1:0]          lookup_value;
    logic [DEFAULT_ADDR_WIDTH-1:0] addr;
  } levelData_t;

  function automatic int ramDepth(input int addrWidth);
    return 1 << addrWidth;
  endfunction

endpackage

// File: rtl/pipe_delay_reg.sv
// Optional single register stage for a data word plus its valid bit.
// ENABLE = 0 is a pure wire; ENABLE = 1 adds one cycle with valid reset to 0.
module pipe_delay_reg #(
  parameter int DATA_WIDTH = 8,
  parameter bit ENABLE     = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_valid_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_valid_o
);

  generate
    if (ENABLE) begin : g_reg
      logic [DATA_WIDTH-1:0] r_data;
      logic                  r_valid;

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          r_data  <= '0;
          r_valid <= 1'b0;
        end else begin
          r_data  <= in_data_i;
          r_valid <= in_valid_i;
        end
      end

      assign out_data_o  = r_data;
      assign out_valid_o = r_valid;
    end else begin : g_wire
      logic w_unused;
      assign w_unused    = clk_i ^ rst_i;
      assign out_data_o  = in_data_i;
      assign out_valid_o = in_valid_i;
    end
  endgenerate

endmodule

// File: rtl/qtree_ram_stage.sv
// Lookup-level RAM stage: config write port, registered read port, bypass and valid kept aligned.
// Define QTREE_RAM_WR_FWD_EN to forward same-cycle write data to the read (default is read-first).
module qtree_ram_stage
  import qtree_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
  parameter int BYPASS_WIDTH   = DEFAULT_BYPASS_WIDTH,
  parameter bit OUT_REG_ENABLE = 1'b0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [ADDR_WIDTH-1:0]   wr_addr_i,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
  input  logic                    wr_enable_i,
  input  logic [ADDR_WIDTH-1:0]   in_read_addr_i,
  input  logic [BYPASS_WIDTH-1:0] in_bypass_i,
  input  logic                    in_valid_i,
  output logic [DATA_WIDTH-1:0]   out_read_data_o,
  output logic [BYPASS_WIDTH-1:0] out_bypass_o,
  output logic                    out_valid_o
);

  localparam int DEPTH    = ramDepth(ADDR_WIDTH);
  localparam int PIPE_WID = DATA_WIDTH + BYPASS_WIDTH;

  // Contents start at zero but are never touched by reset.
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH] = '{default: '0};

  logic [DATA_WIDTH-1:0]   w_rdWord;
  logic [DATA_WIDTH-1:0]   r_rdData;
  logic [BYPASS_WIDTH-1:0] r_rdBypass;
  logic                    r_rdValid;
  logic [PIPE_WID-1:0]     w_pipeOut;

  always_ff @(posedge clk_i) begin
    if (wr_enable_i) begin
      r_mem[wr_addr_i] <= wr_data_i;
    end
  end

`ifdef QTREE_RAM_WR_FWD_EN
  assign w_rdWord = (wr_enable_i && (wr_addr_i == in_read_addr_i)) ? wr_data_i
                                                                    : r_mem[in_read_addr_i];
`else
  assign w_rdWord = r_mem[in_read_addr_i];
`endif

  // Read happens every cycle; valid only qualifies whether anyone cares.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rdData   <= '0;
      r_rdBypass <= '0;
      r_rdValid  <= 1'b0;
    end else begin
      r_rdData   <= w_rdWord;
      r_rdBypass <= in_bypass_i;
      r_rdValid  <= in_valid_i;
    end
  end

  pipe_delay_reg #(
    .DATA_WIDTH (PIPE_WID),
    .ENABLE     (OUT_REG_ENABLE)
  ) u_outReg (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_data_i   ({r_rdData, r_rdBypass}),
    .in_valid_i  (r_rdValid),
    .out_data_o  (w_pipeOut),
    .out_valid_o (out_valid_o)
  );

  assign out_read_data_o = w_pipeOut[PIPE_WID-1:BYPASS_WIDTH];
  assign out_bypass_o    = w_pipeOut[BYPASS_WIDTH-1:0];

endmodule

// File: tb/tb_qtree_ram_stage.sv
// Bench for qtree_ram_stage: one instance per latency setting, driven by the same stimulus.
// Reference model is a plain memory array plus per-cycle expected output history.
module tb_qtree_ram_stage;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int BW = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          we;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;
  logic [AW-1:0] ra;
  logic [BW-1:0] byp;
  logic          vld;

  logic [DW-1:0] o0Data, o1Data;
  logic [BW-1:0] o0Byp, o1Byp;
  logic          o0Vld, o1Vld;

  int testsRun    = 0;
  int testsFailed = 0;

  typedef struct packed {
    logic          v;
    logic [DW-1:0] d;
    logic [BW-1:0] b;
  } outT;

  logic [DW-1:0] modelMem [16];
  outT exp1 = '0;
  outT exp2 = '0;

  qtree_ram_stage #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYPASS_WIDTH(BW), .OUT_REG_ENABLE(1'b0)) dut0 (
    .clk_i(clk), .rst_i(rst), .wr_addr_i(wa), .wr_data_i(wd), .wr_enable_i(we),
    .in_read_addr_i(ra), .in_bypass_i(byp), .in_valid_i(vld),
    .out_read_data_o(o0Data), .out_bypass_o(o0Byp), .out_valid_o(o0Vld)
  );

  qtree_ram_stage #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYPASS_WIDTH(BW), .OUT_REG_ENABLE(1'b1)) dut1 (
    .clk_i(clk), .rst_i(rst), .wr_addr_i(wa), .wr_data_i(wd), .wr_enable_i(we),
    .in_read_addr_i(ra), .in_bypass_i(byp), .in_valid_i(vld),
    .out_read_data_o(o1Data), .out_bypass_o(o1Byp), .out_valid_o(o1Vld)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    testsRun++;
    if (obs !== expv) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle, advance the model across the edge, then check both latencies.
  task automatic applyStimulus(input logic iRst, input logic iWe, input logic [AW-1:0] iWa,
                               input logic [DW-1:0] iWd, input logic [AW-1:0] iRa,
                               input logic [BW-1:0] iByp, input logic iVld);
    logic [DW-1:0] rd;
    outT           s1;
    rst = iRst; we = iWe; wa = iWa; wd = iWd; ra = iRa; byp = iByp; vld = iVld;
    @(posedge clk);
    rd = modelMem[iRa];
`ifdef QTREE_RAM_WR_FWD_EN
    if (iWe && (iWa == iRa)) rd = iWd;
`endif
    s1.v = iVld;
    s1.d = rd;
    s1.b = iByp;
    if (iRst) s1 = '0;
    exp2 = iRst ? outT'('0) : exp1;
    exp1 = s1;
    if (iWe) modelMem[iWa] = iWd;
    @(negedge clk);
    checkOutput("L1 valid", o0Vld,  exp1.v);
    checkOutput("L1 data",  o0Data, exp1.d);
    checkOutput("L1 byp",   o0Byp,  exp1.b);
    checkOutput("L2 valid", o1Vld,  exp2.v);
    checkOutput("L2 data",  o1Data, exp2.d);
    checkOutput("L2 byp",   o1Byp,  exp2.b);
  endtask

  initial begin
    int pat [5] = '{1, 0, 1, 1, 0};
    logic [DW-1:0] rdwExpect;

    for (int i = 0; i < 16; i++) modelMem[i] = '0;
    rst = 1'b1; we = 1'b0; wa = '0; wd = '0; ra = '0; byp = '0; vld = 1'b1;

    // Reset held with valid asserted, then one quiet cycle.
    repeat (3) begin
      applyStimulus(1'b1, 1'b0, '0, '0, '0, 1'b1, 1'b1);
      checkOutput("rst L1 valid", o0Vld, 1'b0);
      checkOutput("rst L2 valid", o1Vld, 1'b0);
    end
    applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    checkOutput("post-rst L1 data", o0Data, 16'h0);
    checkOutput("post-rst L2 data", o1Data, 16'h0);

    // Write then read with both latencies.
    applyStimulus(1'b0, 1'b1, 4'd5, 16'hBEEF, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'd0, 16'h0, 4'd5, 1'b1, 1'b1);
    checkOutput("beef L1 data",  o0Data, 16'hBEEF);
    checkOutput("beef L1 byp",   o0Byp,  1'b1);
    checkOutput("beef L1 valid", o0Vld,  1'b1);
    checkOutput("beef L2 early", o1Vld,  1'b0);
    applyStimulus(1'b0, 1'b0, 4'd0, 16'h0, 4'd0, 1'b0, 1'b0);
    checkOutput("beef L2 data",  o1Data, 16'hBEEF);
    checkOutput("beef L2 byp",   o1Byp,  1'b1);
    checkOutput("beef L2 valid", o1Vld,  1'b1);
    checkOutput("beef L1 done",  o0Vld,  1'b0);

    // Read-during-write on one address.
`ifdef QTREE_RAM_WR_FWD_EN
    rdwExpect = 16'h2222;
`else
    rdwExpect = 16'h1111;
`endif
    applyStimulus(1'b0, 1'b1, 4'd3, 16'h1111, 4'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'd3, 16'h2222, 4'd3, 1'b0, 1'b1);
    checkOutput("rdw same cycle", o0Data, rdwExpect);
    applyStimulus(1'b0, 1'b0, 4'd0, 16'h0, 4'd3, 1'b0, 1'b1);
    checkOutput("rdw next read", o0Data, 16'h2222);

    // Fill mem[i] = i*3, then stream every address back-to-back.
    for (int i = 0; i < 16; i++)
      applyStimulus(1'b0, 1'b1, AW'(i), DW'(i * 3), '0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b0, '0, '0, AW'(i), BW'(i[0]), 1'b1);
      checkOutput("stream data",  o0Data, DW'(i * 3));
      checkOutput("stream byp",   o0Byp,  BW'(i[0]));
      checkOutput("stream valid", o0Vld,  1'b1);
    end
    applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);

    // Valid gaps shift through unchanged.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 1'b0, '0, '0, AW'(k), 1'b0, pat[k][0]);
      checkOutput("gap L1", o0Vld, pat[k][0]);
      if (k > 0) checkOutput("gap L2", o1Vld, pat[k-1][0]);
    end
    applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
    checkOutput("gap L2 tail", o1Vld, pat[4][0]);

    // Randomized traffic with occasional mid-stream resets.
    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom_range(0, 39) == 0), 1'($urandom), AW'($urandom), DW'($urandom),
                    AW'($urandom), BW'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
